fx_gate_ctrl: RTL and testbench

FX_GATE_CTRL -- requirements
Module: fx_gate_ctrl

---
 rtl/fx_gate_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fx_gate_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fx_gate_ctrl.sv
// fx_gate_ctrl: stereo noise gate with attack/hold/release gain ramping.
// Level is the larger channel magnitude; the gate opens when the level reaches
// the threshold, ramps gain up one LSB per attack step, holds for HOLD_SAMPLES
// samples after the level drops, then ramps down one LSB per release step.
module fx_gate_ctrl #(
  parameter int DATA_W       = 16,
  parameter int PARAM_W      = 8,
  parameter int HOLD_SAMPLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_en,
  input  logic [1:0][DATA_W-1:0] audio_in,
  input  logic [PARAM_W-1:0]     fx_threshold,
  input  logic [PARAM_W-1:0]     fx_attack,
  input  logic [PARAM_W-1:0]     fx_release,
  output logic [1:0][DATA_W-1:0] audio_out,
  output logic                   out_valid,
  output logic [PARAM_W:0]       gain_out,
  output logic [2:0]             gate_state
);

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam int LVL_W  = DATA_W - 1;
  localparam int PROD_W = DATA_W + PARAM_W + 2;
  localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);
  localparam logic [PARAM_W:0]  GAIN_MAX  = {1'b1, {PARAM_W{1'b0}}};

  state_t                  state_reg, state_next;
  logic [PARAM_W:0]        gain_reg, gain_next;
  logic [PARAM_W-1:0]      div_reg, div_next;
  logic [HOLD_W-1:0]       hold_reg, hold_next;
  logic [1:0][DATA_W-1:0]  audio_reg, audio_next;
  logic                    out_valid_reg;

  logic [1:0][LVL_W-1:0]   mag;
  logic [1:0][DATA_W-1:0]  scaled;
  logic [LVL_W-1:0]        level;
  logic [LVL_W-1:0]        thr_ext;
  logic                    hit;
  logic [PARAM_W-1:0]      active_div;
  logic                    step;

  // Per-channel magnitude (most negative value saturates) and gain scaling.
  // Scaling always uses the registered gain, i.e. the gain before this
  // sample's update.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [DATA_W-1:0]        neg_x;
      logic signed [PROD_W-1:0] smp_ext;
      logic signed [PROD_W-1:0] gain_ext;
      logic signed [PROD_W-1:0] prod;

      assign neg_x    = ~audio_in[gi] + 1'b1;
      // neg_x keeps its sign bit only for the most negative input
      assign mag[gi]  = !audio_in[gi][DATA_W-1] ? audio_in[gi][LVL_W-1:0] :
                        (neg_x[DATA_W-1] ? {LVL_W{1'b1}} : neg_x[LVL_W-1:0]);
      assign smp_ext  = {{(PROD_W-DATA_W){audio_in[gi][DATA_W-1]}}, audio_in[gi]};
      assign gain_ext = {{(PROD_W-PARAM_W-1){1'b0}}, gain_reg};
      assign prod     = smp_ext * gain_ext;
      assign scaled[gi] = DATA_W'(prod >>> PARAM_W);
    end
  endgenerate

  // Gate detector and ramp step decision.
  always_comb begin
    level      = (mag[0] > mag[1]) ? mag[0] : mag[1];
    thr_ext    = LVL_W'(fx_threshold) << (LVL_W - PARAM_W);
    hit        = (level >= thr_ext);
    active_div = (state_reg == ST_ATTACK) ? fx_attack : fx_release;
    step       = (div_reg >= active_div);
  end

  // Next-state, gain, counters and output sample; nothing moves without sample_en.
  always_comb begin
    state_next = state_reg;
    gain_next  = gain_reg;
    div_next   = div_reg;
    hold_next  = hold_reg;
    audio_next = audio_reg;
    if (sample_en) begin
      audio_next = scaled;
      case (state_reg)
        ST_CLOSED: begin
          gain_next = '0;
          if (hit) begin
            state_next = ST_ATTACK;
            div_next   = '0;
          end
        end
        ST_ATTACK: begin
          if (step) begin
            div_next = '0;
            if (gain_reg >= GAIN_MAX - 1'b1) begin
              gain_next  = GAIN_MAX;
              state_next = ST_OPEN;
            end else begin
              gain_next = gain_reg + 1'b1;
            end
          end else begin
            div_next = div_reg + 1'b1;
          end
        end
        ST_OPEN: begin
          gain_next = GAIN_MAX;
          if (!hit) begin
            state_next = ST_HOLD;
            hold_next  = '0;
            div_next   = '0;
          end
        end
        ST_HOLD: begin
          if (hit) begin
            state_next = ST_OPEN;
            div_next   = '0;
          end else if (hold_reg == HOLD_LAST) begin
            state_next = ST_RELEASE;
            div_next   = '0;
          end else begin
            hold_next = hold_reg + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (hit) begin
            // re-attack continues from the current gain, no jump
            state_next = ST_ATTACK;
            div_next   = '0;
          end else if (step) begin
            div_next = '0;
            if (gain_reg <= (PARAM_W+1)'(1)) begin
              gain_next  = '0;
              state_next = ST_CLOSED;
            end else begin
              gain_next = gain_reg - 1'b1;
            end
          end else begin
            div_next = div_reg + 1'b1;
          end
        end
        default: begin
          state_next = ST_CLOSED;
          gain_next  = '0;
          div_next   = '0;
          hold_next  = '0;
        end
      endcase
    end
  end

  // State register with asynchronous reset that aborts any ramp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_CLOSED;
      gain_reg      <= '0;
      div_reg       <= '0;
      hold_reg      <= '0;
      audio_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gain_reg      <= gain_next;
      div_reg       <= div_next;
      hold_reg      <= hold_next;
      audio_reg     <= audio_next;
      out_valid_reg <= sample_en;
    end
  end

  assign audio_out  = audio_reg;
  assign out_valid  = out_valid_reg;
  assign gain_out   = gain_reg;
  assign gate_state = state_reg;

endmodule

// File: tb/tb_fx_gate_ctrl.sv
// Directed bench for fx_gate_ctrl: full attack, threshold boundary, hold
// re-trigger, release with live divider change, re-attack, resets mid-ramp,
// and full release to closed. Expected values are hand-computed.
module tb_fx_gate_ctrl;

  localparam int DATA_W  = 16;
  localparam int PARAM_W = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   sample_en = 1'b0;
  logic [1:0][DATA_W-1:0] audio_in = '0;
  logic [PARAM_W-1:0]     thr = '0;
  logic [PARAM_W-1:0]     atk = '0;
  logic [PARAM_W-1:0]     rel = '0;
  logic [1:0][DATA_W-1:0] audio_out;
  logic                   out_valid;
  logic [PARAM_W:0]       gain_out;
  logic [2:0]             gate_state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fx_gate_ctrl #(.DATA_W(DATA_W), .PARAM_W(PARAM_W), .HOLD_SAMPLES(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_en   (sample_en),
    .audio_in    (audio_in),
    .fx_threshold(thr),
    .fx_attack   (atk),
    .fx_release  (rel),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .gain_out    (gain_out),
    .gate_state  (gate_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    $display("[%0t] %s observed=0x%0h expected=0x%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sg(input string tag, input logic [2:0] st, input logic [PARAM_W:0] g);
    check({tag, "_state"}, 32'(gate_state), 32'(st));
    check({tag, "_gain"}, 32'(gain_out), 32'(g));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gain"}, 32'(gain_out), 32'd0);
    check({tag, "_state"}, 32'(gate_state), 32'd0);
    check({tag, "_audio"}, 32'(audio_out), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
  endtask

  // One sample on the next edge; outputs are sampled 1 time unit later.
  task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    audio_in[0] = l;
    audio_in[1] = r;
    sample_en   = 1'b1;
    @(posedge clk);
    #1;
    sample_en   = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    for (int i = 0; i < n; i++) send(l, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // hot input without strobe must not move the gate
    thr = 8'h10; atk = 8'd0; rel = 8'd3;
    audio_in[0] = 16'h0900;
    audio_in[1] = 16'h0900;
    repeat (3) @(posedge clk);
    #1;
    check("idle_state", 32'(gate_state), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);

    // attack run: sample n (n>=2) leaves gain n-1
    send(16'h0900, 16'h0900);
    check_sg("s1", 3'd1, 9'd0);
    check("s1_valid", 32'(out_valid), 32'd1);
    check("s1_audio", 32'(audio_out[0]), 32'h0);
    @(posedge clk);
    #1;
    check("gap_valid", 32'(out_valid), 32'd0);
    check("gap_gain", 32'(gain_out), 32'd0);
    send(16'h0900, 16'h0900);
    check_sg("s2", 3'd1, 9'd1);
    send(16'h0900, 16'h0900);
    check_sg("s3", 3'd1, 9'd2);
    check("s3_audio_l", 32'(audio_out[0]), 32'h0009);
    check("s3_audio_r", 32'(audio_out[1]), 32'h0009);
    send_n(253, 16'h0900, 16'h0900);
    check_sg("s256", 3'd1, 9'd255);
    send(16'h0900, 16'h0900);
    check_sg("s257", 3'd2, 9'h100);
    check("s257_audio", 32'(audio_out[0]), 32'h08F7);
    send(16'h0900, 16'h0900);
    check("unity_audio", 32'(audio_out[0]), 32'h0900);

    // most negative sample, threshold 0xFF, exact unity pass-through
    thr = 8'hFF;
    send(16'h8000, 16'h0000);
    check("neg_state", 32'(gate_state), 32'd2);
    check("neg_audio_l", 32'(audio_out[0]), 32'h8000);
    check("neg_audio_r", 32'(audio_out[1]), 32'h0000);
    send(16'h7F80, 16'h0000);
    check("thr_equal_state", 32'(gate_state), 32'd2);
    thr = 8'h10;

    // hold re-triggered at hold_cnt=30
    send(16'h0010, 16'h0010);
    check("hold_enter", 32'(gate_state), 32'd3);
    check("hold_audio", 32'(audio_out[0]), 32'h0010);
    send_n(30, 16'h0010, 16'h0010);
    check_sg("hold30", 3'd3, 9'h100);
    send(16'h0900, 16'h0900);
    check_sg("hold_reopen", 3'd2, 9'h100);

    // full hold, then release with rel=3
    send(16'h0010, 16'h0010);
    send_n(63, 16'h0010, 16'h0010);
    check("hold63", 32'(gate_state), 32'd3);
    send(16'h0010, 16'h0010);
    check_sg("rel_enter", 3'd4, 9'h100);
    send_n(3, 16'h0010, 16'h0010);
    check_sg("rel_3", 3'd4, 9'h100);
    send(16'h0010, 16'h0010);
    check_sg("rel_4", 3'd4, 9'd255);
    send_n(2, 16'h0010, 16'h0010);
    rel = 8'd1;
    send(16'h0010, 16'h0010);
    check("rel_live_div", 32'(gain_out), 32'd254);
    rel = 8'd3;
    send_n(616, 16'h0010, 16'h0010);
    check_sg("rel_100", 3'd4, 9'd100);

    // re-attack from 100, negative right channel
    send(16'h0900, 16'hF700);
    check_sg("reatk", 3'd1, 9'd100);
    check("reatk_l", 32'(audio_out[0]), 32'h0384);
    check("reatk_r", 32'(audio_out[1]), 32'hFC7C);
    send(16'h0900, 16'hF700);
    check("reatk2_gain", 32'(gain_out), 32'd101);
    send(16'h0900, 16'hF700);
    check("reatk3_l", 32'(audio_out[0]), 32'h038D);
    check("reatk3_r", 32'(audio_out[1]), 32'hFC73);

    // asynchronous reset mid-ramp
    reset = 1'b1;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(16'h0900, 16'h0900);
    check_sg("post_rst", 3'd1, 9'd0);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    send_n(50, 16'h0900, 16'h0900);
    check_sg("atk50", 3'd1, 9'd50);
    reset = 1'b1;
    #1;
    check_zero("rst_atk50");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // full run to CLOSED with rel=0
    rel = 8'd0;
    send(16'h0900, 16'h0900);
    send_n(256, 16'h0900, 16'h0900);
    check_sg("run3_open", 3'd2, 9'h100);
    send_n(65, 16'h0010, 16'h0010);
    check_sg("run3_rel", 3'd4, 9'h100);
    send_n(255, 16'h0010, 16'h0010);
    check_sg("run3_g1", 3'd4, 9'd1);
    send(16'h0010, 16'h0010);
    check_sg("run3_closed", 3'd0, 9'd0);
    send(16'h0010, 16'h0010);
    check("closed_audio", 32'(audio_out), 32'd0);
    check("closed_state", 32'(gate_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
